tcam_access_ctrl: RTL
=====================

TCAM_ACCESS_CTRL -- requirements
Module: tcam_access_ctrl

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 28, meaning TCAM key/write-address width.
REQ-002 The module SHALL have parameter DATA_W, default 32, meaning write-data width.
REQ-003 The module SHALL have parameter PMA_W, default 6, meaning priority-match-address width.
REQ-004 The module SHALL have port in_clk, input, 1, meaning the single clock.
REQ-005 The module SHALL have port in_rst, input, 1, meaning reset, asynchronous and active-high.
REQ-006 The module SHALL have port in_req_valid, input, 1, meaning a command is offered.
REQ-007 The module SHALL have port out_req_ready, output, 1, meaning a command can be accepted.
REQ-008 The module SHALL have port in_req_write, input, 1, meaning 1 = write, 0 = search.
REQ-009 The module SHALL have ports in_req_addr (ADDR_W), in_req_wdata (DATA_W) and in_req_wmask (4), all inputs, carrying the command payload.
REQ-010 The module SHALL have port out_resp_valid, output, 1, meaning a response is held.
REQ-011 The module SHALL have port in_resp_ready, input, 1, meaning the consumer takes the response.
REQ-012 The module SHALL have ports out_resp_write (1) and out_resp_pma (PMA_W), both outputs, giving the response type and the match address.
REQ-013 The module SHALL have ports out_tcam_csb (1), out_tcam_web (1), out_tcam_wmask (4), out_tcam_addr (ADDR_W) and out_tcam_wdata (DATA_W), all outputs, driving the TCAM array.
REQ-014 The module SHALL have port in_tcam_pma, input, PMA_W, meaning the TCAM priority-encoder output.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-016 out_req_ready SHALL be 1 only in IDLE.
REQ-017 When in_req_valid and out_req_ready are both high at a clock edge, the module SHALL register the payload and move to ISSUE.
REQ-018 In ISSUE, for exactly one cycle, the module SHALL drive out_tcam_csb=0 and out_tcam_web=~write, with addr, wdata and wmask taken from the registered command.
REQ-019 ISSUE SHALL move unconditionally to WAIT, which covers the one-cycle array read latency; out_tcam_csb SHALL be 1 in WAIT.
REQ-020 For a search, in_tcam_pma SHALL be sampled into out_resp_pma at the edge that ends WAIT; for a write, out_resp_pma SHALL be 0.
REQ-021 WAIT SHALL move to RESP, where out_resp_valid=1 and out_resp_write equals the registered write bit.
REQ-022 In RESP, the response SHALL stay stable until in_resp_ready=1, after which the FSM SHALL return to IDLE.
REQ-023 A new command SHALL NOT be accepted in the cycle the response is consumed; minimum spacing is 4 cycles per command.
REQ-024 Outside ISSUE, the module SHALL drive out_tcam_csb=1, out_tcam_web=1, and out_tcam_addr, out_tcam_wdata and out_tcam_wmask=0.
REQ-025 in_req_* changes while out_req_ready=0 SHALL have no effect.

Reset
REQ-026 While in_rst=1, the FSM SHALL be in IDLE with out_req_ready=1, out_resp_valid=0, out_resp_write=0, out_resp_pma=0, out_tcam_csb=1, out_tcam_web=1, and all other outputs 0.
REQ-027 Reset asserted in ISSUE, WAIT or RESP SHALL abort the command, which SHALL produce no response after reset is released.

Configuration
REQ-028 When TCAM_ACCESS_CTRL_STATS_EN is defined, the module SHALL add 16-bit outputs out_stat_searches and out_stat_writes, each incremented on the edge leaving ISSUE for its command type, saturating at 0xFFFF, and cleared by reset.
REQ-029 When TCAM_ACCESS_CTRL_STATS_EN is not defined, those ports and counters SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-030 A package tcam_pkg SHALL hold the state enum, the ADDR_W, DATA_W and PMA_W default constants, and a command struct {write, addr, wdata, wmask}.
REQ-031 The module SHALL be flat, with no sub-modules.

Verification
REQ-032 Release reset, then check idle outputs: out_req_ready=1, out_tcam_csb=1, out_resp_valid=0.
REQ-033 Write addr=0x0000105, wdata=0xA5A5A5A5, wmask=0xF -> exactly one cycle with csb=0, web=0 and addr 0x0000105, then resp_valid=1, resp_write=1, pma=0.
REQ-034 Search addr=0x0204081 with the model returning pma=0x2A -> one cycle with csb=0, web=1, then resp_pma=0x2A, 3 cycles after acceptance.
REQ-035 Hold in_resp_ready=0 for 5 cycles in RESP -> response stable, out_req_ready=0, no further csb pulses.
REQ-036 Assert in_rst during WAIT -> immediate idle outputs, and no out_resp_valid after reset is released.
REQ-037 With stats enabled, perform 3 searches and 2 writes -> out_stat_searches=3, out_stat_writes=2; a counter preloaded to 0xFFFF stays at 0xFFFF on the next increment.

Source files
------------

// File: rtl/tcam_pkg.sv
// tcam_pkg
// Shared definitions for the TCAM access controller:
//   - default key/address, write-data and match-address widths
//   - the controller state encoding
//   - a command record {write, addr, wdata, wmask} at the default widths
package tcam_pkg;

  localparam int TCAM_ADDR_W = 28;
  localparam int TCAM_DATA_W = 32;
  localparam int TCAM_PMA_W  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic                   write;
    logic [TCAM_ADDR_W-1:0] addr;
    logic [TCAM_DATA_W-1:0] wdata;
    logic [3:0]             wmask;
  } tcam_cmd_t;

endpackage

// File: rtl/tcam_access_ctrl_if.sv
// tcam_access_ctrl_if
// Bundles the command, response and TCAM-array signals of tcam_access_ctrl.
//   master : the command producer / response consumer, which also models the
//            array and therefore drives tcam_pma
//   slave  : the controller side
// Clock and reset are not part of the bundle.
interface tcam_access_ctrl_if
  import tcam_pkg::*;
#(
  parameter int ADDR_W = TCAM_ADDR_W,
  parameter int DATA_W = TCAM_DATA_W,
  parameter int PMA_W  = TCAM_PMA_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_wmask;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_write;
  logic [PMA_W-1:0]  resp_pma;

  logic              tcam_csb;
  logic              tcam_web;
  logic [3:0]        tcam_wmask;
  logic [ADDR_W-1:0] tcam_addr;
  logic [DATA_W-1:0] tcam_wdata;
  logic [PMA_W-1:0]  tcam_pma;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask,
    output resp_ready, tcam_pma,
    input  req_ready, resp_valid, resp_write, resp_pma,
    input  tcam_csb, tcam_web, tcam_wmask, tcam_addr, tcam_wdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask,
    input  resp_ready, tcam_pma,
    output req_ready, resp_valid, resp_write, resp_pma,
    output tcam_csb, tcam_web, tcam_wmask, tcam_addr, tcam_wdata
  );

endinterface

// File: rtl/tcam_access_ctrl.sv
// tcam_access_ctrl
// Sequences one command at a time onto a TCAM array with a one-cycle read
// latency: accept (IDLE) -> single array access (ISSUE) -> wait for the
// priority encoder (WAIT) -> hold the response until consumed (RESP).
//
// Ports
//   in_clk, in_rst               clock, asynchronous active-high reset
//   in_req_valid / out_req_ready command handshake (ready only in IDLE)
//   in_req_write, in_req_addr,
//   in_req_wdata, in_req_wmask   command payload (1 = write, 0 = search)
//   out_resp_valid / in_resp_ready response handshake
//   out_resp_write, out_resp_pma response type and priority match address
//   out_tcam_*                   array strobes and payload (csb/web active low)
//   in_tcam_pma                  array priority-encoder output
//   out_stat_searches/_writes    saturating command counters, present only
//                                when TCAM_ACCESS_CTRL_STATS_EN is defined
module tcam_access_ctrl
  import tcam_pkg::*;
#(
  parameter int ADDR_W = TCAM_ADDR_W,
  parameter int DATA_W = TCAM_DATA_W,
  parameter int PMA_W  = TCAM_PMA_W
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_req_valid,
  output logic              out_req_ready,
  input  logic              in_req_write,
  input  logic [ADDR_W-1:0] in_req_addr,
  input  logic [DATA_W-1:0] in_req_wdata,
  input  logic [3:0]        in_req_wmask,
  output logic              out_resp_valid,
  input  logic              in_resp_ready,
  output logic              out_resp_write,
  output logic [PMA_W-1:0]  out_resp_pma,
  output logic              out_tcam_csb,
  output logic              out_tcam_web,
  output logic [3:0]        out_tcam_wmask,
  output logic [ADDR_W-1:0] out_tcam_addr,
  output logic [DATA_W-1:0] out_tcam_wdata,
`ifdef TCAM_ACCESS_CTRL_STATS_EN
  output logic [15:0]       out_stat_searches,
  output logic [15:0]       out_stat_writes,
`endif
  input  logic [PMA_W-1:0]  in_tcam_pma
);

  state_t state_q, state_d;

  logic              cmd_write_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  logic [3:0]        cmd_wmask_q;
  logic [PMA_W-1:0]  pma_q;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus all Moore outputs. The array bus is forced to its
  // inactive pattern in every state except the single ISSUE cycle.
  always_comb begin
    state_d        = state_q;
    out_req_ready  = 1'b0;
    out_resp_valid = 1'b0;
    out_resp_write = 1'b0;
    out_resp_pma   = '0;
    out_tcam_csb   = 1'b1;
    out_tcam_web   = 1'b1;
    out_tcam_wmask = '0;
    out_tcam_addr  = '0;
    out_tcam_wdata = '0;
    case (state_q)
      IDLE: begin
        out_req_ready = 1'b1;
        if (in_req_valid) state_d = ISSUE;
      end
      ISSUE: begin
        out_tcam_csb   = 1'b0;
        out_tcam_web   = ~cmd_write_q;
        out_tcam_wmask = cmd_wmask_q;
        out_tcam_addr  = cmd_addr_q;
        out_tcam_wdata = cmd_wdata_q;
        state_d        = WAIT;
      end
      WAIT: begin
        state_d = RESP;
      end
      RESP: begin
        out_resp_valid = 1'b1;
        out_resp_write = cmd_write_q;
        out_resp_pma   = pma_q;
        // Returning to IDLE (not straight to a new accept) is what keeps
        // a command from being taken in the cycle its response is consumed.
        if (in_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Payload is captured only at acceptance, so request-side changes while
  // busy cannot disturb the command in flight.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_wmask_q <= '0;
    end else if (state_q == IDLE && in_req_valid) begin
      cmd_write_q <= in_req_write;
      cmd_addr_q  <= in_req_addr;
      cmd_wdata_q <= in_req_wdata;
      cmd_wmask_q <= in_req_wmask;
    end
  end

  // The encoder output is valid during WAIT; writes report match address 0.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst)                pma_q <= '0;
    else if (state_q == WAIT)  pma_q <= cmd_write_q ? '0 : in_tcam_pma;
  end

`ifdef TCAM_ACCESS_CTRL_STATS_EN
  logic [15:0] stat_searches_q;
  logic [15:0] stat_writes_q;

  // Counted on the edge leaving ISSUE; both counters stick at all-ones.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      stat_searches_q <= '0;
      stat_writes_q   <= '0;
    end else if (state_q == ISSUE) begin
      if (cmd_write_q) begin
        if (stat_writes_q != 16'hFFFF) stat_writes_q <= stat_writes_q + 16'd1;
      end else begin
        if (stat_searches_q != 16'hFFFF) stat_searches_q <= stat_searches_q + 16'd1;
      end
    end
  end

  assign out_stat_searches = stat_searches_q;
  assign out_stat_writes   = stat_writes_q;
`endif

endmodule
